// File: rtl/ra_list_walker.sv
// Region-array list walker: fetches region entries from VRAM, emits tile
// descriptors, walks the enabled object lists and dispatches primitives.
module ra_list_walker #(
  parameter int ADDR_W = 24,
  parameter int NUM_LISTS = 5,
  parameter int MAX_LINKS = 1023,
  parameter logic [3*NUM_LISTS-1:0] LIST_ORDER = {3'd3, 3'd2, 3'd1, 3'd4, 3'd0}
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] region_base,
  input  logic [ADDR_W-1:0] param_base,
  input  logic              fmt_v2,
  input  logic [4:0]        list_en,
  output logic              vram_rd,
  output logic [ADDR_W-1:0] vram_addr,
  input  logic              vram_wait,
  input  logic              vram_valid,
  input  logic [31:0]       vram_din,
  output logic              tile_start,
  output logic [5:0]        tile_x,
  output logic [5:0]        tile_y,
  output logic              tile_zclear_n,
  output logic              tile_flush_n,
  output logic              tile_last,
  output logic              poly_req,
  output logic [ADDR_W-1:0] poly_addr,
  output logic [31:0]       poly_word,
  output logic [2:0]        poly_list,
  input  logic              poly_ack,
  output logic              tile_done,
  output logic              frame_done,
  output logic              busy,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam int SLOT_W = $clog2(NUM_LISTS + 1);
  localparam int LINK_W = $clog2(MAX_LINKS + 1);
  localparam logic [ADDR_W-1:0] PARAM_MASK = {{(ADDR_W-20){1'b1}}, 20'b0};

  typedef enum logic [3:0] {
    IDLE, RA_RD, TILE_GO, SEL, OPB_RD, OPB_DEC, POLY, TILE_END, DONE, ERR
  } state_t;

  state_t             state;
  logic               rd_pending;
  logic [2:0]         ra_idx;
  logic [SLOT_W-1:0]  slot;
  logic [LINK_W-1:0]  link_cnt;
  logic [ADDR_W-1:0]  next_addr;
  logic [31:0]        opb_word;
  logic [5:0]         ctrl_x;
  logic [5:0]         ctrl_y;
  logic               ctrl_last;
  logic               ctrl_zclear_n;
  logic               ctrl_flush_n;
  logic               ptr_dis  [0:4];
  logic [ADDR_W-1:0]  ptr_addr [0:4];
  logic [2:0]         cur_idx;
  logic [2:0]         ra_last;
  logic               rd_data;

  // Map the current slot to a list index; slots past the end read as 0.
  always_comb begin
    cur_idx = 3'd0;
    for (int i = 0; i < NUM_LISTS; i++) begin
      if (slot == SLOT_W'(i)) cur_idx = LIST_ORDER[3*i +: 3];
    end
  end

  assign ra_last = fmt_v2 ? 3'd5 : 3'd4;
  assign rd_data = rd_pending && vram_valid;
  assign busy    = (state != IDLE) && (state != ERR);

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      rd_pending    <= 1'b0;
      ra_idx        <= 3'd0;
      slot          <= '0;
      link_cnt      <= '0;
      next_addr     <= '0;
      opb_word      <= '0;
      ctrl_x        <= '0;
      ctrl_y        <= '0;
      ctrl_last     <= 1'b0;
      ctrl_zclear_n <= 1'b0;
      ctrl_flush_n  <= 1'b0;
      for (int k = 0; k < 5; k++) begin
        ptr_dis[k]  <= 1'b1;
        ptr_addr[k] <= '0;
      end
      vram_rd       <= 1'b0;
      vram_addr     <= '0;
      tile_start    <= 1'b0;
      tile_x        <= '0;
      tile_y        <= '0;
      tile_zclear_n <= 1'b0;
      tile_flush_n  <= 1'b0;
      tile_last     <= 1'b0;
      poly_req      <= 1'b0;
      poly_addr     <= '0;
      poly_word     <= '0;
      poly_list     <= '0;
      tile_done     <= 1'b0;
      frame_done    <= 1'b0;
      err           <= 1'b0;
      err_code      <= 2'd0;
    end else begin
      tile_start <= 1'b0;
      tile_done  <= 1'b0;
      frame_done <= 1'b0;
      // A request is accepted on the first cycle without wait; the data follows later.
      if (vram_rd && !vram_wait) begin
        vram_rd    <= 1'b0;
        rd_pending <= 1'b1;
      end
      case (state)
        IDLE, ERR: begin
          if (start) begin
            err       <= 1'b0;
            err_code  <= 2'd0;
            vram_addr <= region_base;
            vram_rd   <= 1'b1;
            ra_idx    <= 3'd0;
            state     <= RA_RD;
          end
        end
        RA_RD: begin
          if (rd_data) begin
            rd_pending <= 1'b0;
            if (ra_idx == 3'd0) begin
              ctrl_x        <= vram_din[7:2];
              ctrl_y        <= vram_din[13:8];
              ctrl_last     <= vram_din[31];
              ctrl_zclear_n <= vram_din[30];
              ctrl_flush_n  <= vram_din[28];
            end else begin
              ptr_dis[ra_idx - 3'd1]  <= vram_din[31];
              ptr_addr[ra_idx - 3'd1] <= vram_din[ADDR_W-1:0];
            end
            if (ra_idx == ra_last) begin
              if (!fmt_v2) begin
                ptr_dis[4]  <= 1'b1;
                ptr_addr[4] <= '0;
              end
              next_addr     <= vram_addr + ADDR_W'(4);
              tile_x        <= ctrl_x;
              tile_y        <= ctrl_y;
              tile_last     <= ctrl_last;
              tile_zclear_n <= ctrl_zclear_n;
              tile_flush_n  <= ctrl_flush_n;
              tile_start    <= 1'b1;
              state         <= TILE_GO;
            end else begin
              ra_idx    <= ra_idx + 3'd1;
              vram_addr <= vram_addr + ADDR_W'(4);
              vram_rd   <= 1'b1;
            end
          end
        end
        TILE_GO: begin
          slot  <= '0;
          state <= SEL;
        end
        SEL: begin
          if (slot == SLOT_W'(NUM_LISTS)) begin
            tile_done <= 1'b1;
            state     <= TILE_END;
          end else if (list_en[cur_idx] && !ptr_dis[cur_idx]) begin
            vram_addr <= ptr_addr[cur_idx];
            vram_rd   <= 1'b1;
            link_cnt  <= '0;
            state     <= OPB_RD;
          end else begin
            slot <= slot + SLOT_W'(1);
          end
        end
        OPB_RD: begin
          if (rd_data) begin
            rd_pending <= 1'b0;
            opb_word   <= vram_din;
            // The word that reaches the link budget is treated as an overrun.
            if (link_cnt == LINK_W'(MAX_LINKS - 1)) begin
              err      <= 1'b1;
              err_code <= 2'd2;
              state    <= ERR;
            end else begin
              link_cnt <= link_cnt + LINK_W'(1);
              state    <= OPB_DEC;
            end
          end
        end
        OPB_DEC: begin
          if (!opb_word[31] || opb_word[31:29] == 3'b100 || opb_word[31:29] == 3'b101) begin
            poly_addr <= (param_base & PARAM_MASK) + ADDR_W'({opb_word[20:0], 2'b00});
            poly_word <= opb_word;
            poly_list <= cur_idx;
            poly_req  <= 1'b1;
            state     <= POLY;
          end else if (opb_word[31:29] == 3'b111) begin
            if (opb_word[28]) begin
              slot  <= slot + SLOT_W'(1);
              state <= SEL;
            end else begin
              vram_addr <= ADDR_W'({opb_word[23:2], 2'b00});
              vram_rd   <= 1'b1;
              state     <= OPB_RD;
            end
          end else begin
            err      <= 1'b1;
            err_code <= 2'd1;
            state    <= ERR;
          end
        end
        POLY: begin
          if (poly_ack) begin
            poly_req  <= 1'b0;
            vram_addr <= vram_addr + ADDR_W'(4);
            vram_rd   <= 1'b1;
            state     <= OPB_RD;
          end
        end
        TILE_END: begin
          if (tile_last) begin
            frame_done <= 1'b1;
            state      <= DONE;
          end else begin
            vram_addr <= next_addr;
            vram_rd   <= 1'b1;
            ra_idx    <= 3'd0;
            state     <= RA_RD;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ra_list_walker.md
RA_LIST_WALKER -- requirements
Module: ra_list_walker

Interface
REQ-001 Parameter ADDR_W, default 24: VRAM byte-address width.
REQ-002 Parameter NUM_LISTS, default 5: object-list pointers per region entry, excluding the punch-through word.
REQ-003 Parameter MAX_LINKS, default 1023: maximum OPB words walked per list before the list is declared overrun.
REQ-004 Parameter LIST_ORDER, default {3'd3,3'd2,3'd1,3'd4,3'd0}: list processing order, 3 bits per slot, LSB slot first; index 0=opaque, 1=op_mod, 2=trans, 3=tr_mod, 4=puncht.
REQ-005 Port clock, input, 1: sole clock.
REQ-006 Port reset, input, 1: synchronous, active-high reset.
REQ-007 Port start, input, 1: single-cycle frame trigger.
REQ-008 Port region_base / param_base, inputs, ADDR_W each: RA start address and parameter base.
REQ-009 Port fmt_v2, input, 1: region entry carries a puncht word (6 words total; 5 words when low).
REQ-010 Port list_en, input, 5: runtime enable per list index.
REQ-011 Ports vram_rd (out, 1), vram_addr (out, ADDR_W), vram_wait (in, 1), vram_valid (in, 1), vram_din (in, 32): read port.
REQ-012 Ports tile_start (out, 1), tile_x (out, 6), tile_y (out, 6), tile_zclear_n (out, 1), tile_flush_n (out, 1), tile_last (out, 1): tile descriptor.
REQ-013 Ports poly_req (out, 1), poly_addr (out, ADDR_W), poly_word (out, 32), poly_list (out, 3), poly_ack (in, 1): primitive dispatch handshake.
REQ-014 Ports tile_done (out, 1), frame_done (out, 1), busy (out, 1), err (out, 1), err_code (out, 2).

Function
REQ-015 States: IDLE, RA_RD, TILE_GO, SEL, OPB_RD, OPB_DEC, POLY, TILE_END, DONE, ERR.
REQ-016 Read handshake: vram_rd asserts with vram_addr and holds until a cycle with vram_wait low; at most one read outstanding; data is consumed only on vram_valid.
REQ-017 IDLE: start moves to RA_RD with address region_base; start outside IDLE is ignored.
REQ-018 RA_RD: reads control, opaque, op_mod, trans, tr_mod, then puncht only if fmt_v2 (else puncht forced to 32'h8000_0000); address increments by 4 per word; the next-entry address is saved.
REQ-019 TILE_GO: one-cycle tile_start pulse; tile_x=ctrl[7:2], tile_y=ctrl[13:8], tile_last=ctrl[31], tile_zclear_n=ctrl[30], tile_flush_n=ctrl[28]; all held until the next TILE_GO; slot counter cleared.
REQ-020 SEL: one slot per cycle. A list is walked only if list_en[idx]=1 and pointer[31]=0. When walked: vram_addr=pointer[ADDR_W-1:0], link counter cleared, go to OPB_RD. Otherwise advance the slot. After the last slot, go to TILE_END.
REQ-021 OPB_DEC, word[31]=0, or [31:29]=100 or 101: poly_addr=(param_base & {ADDR_W-20 ones, 20 zeros})+{word[20:0],2'b00} truncated to ADDR_W; poly_word=word; poly_list=idx; go to POLY.
REQ-022 OPB_DEC, [31:29]=111 and word[28]=1: end of list; next slot via SEL.
REQ-023 OPB_DEC, [31:29]=111 and word[28]=0: link; vram_addr={word[23:2],2'b00}; go to OPB_RD.
REQ-024 OPB_DEC, [31:29]=110: go to ERR with err_code=1.
REQ-025 POLY: poly_req held high until the cycle poly_ack is sampled high; it then deasserts the next cycle, and the walker reads the next sequential OPB word (address+4).
REQ-026 The link counter increments per OPB word read; reaching MAX_LINKS moves to ERR with err_code=2.
REQ-027 TILE_END: one-cycle tile_done pulse; if tile_last, go to DONE; else re-enter RA_RD at the saved next-entry address.
REQ-028 DONE: one-cycle frame_done pulse, then IDLE.
REQ-029 ERR: err held high, err_code held, outputs quiet until reset or start; start clears err and begins a new frame.
REQ-030 busy is high in every state except IDLE and ERR.
REQ-031 An all-disabled entry (every pointer[31]=1) still produces tile_start and tile_done, 2+NUM_LISTS cycles apart at minimum.
REQ-032 poly_ack arriving in the same cycle as poly_req first rises is valid: single-cycle handshake.

Reset
REQ-033 On reset at any clock edge, including mid-read or mid-handshake: state=IDLE.
REQ-034 On reset, all pulses and vram_rd, poly_req, err, and busy drop to 0.
REQ-035 On reset, tile fields, poly_addr, poly_word, and vram_addr go to 0, and err_code to 0.
REQ-036 After reset, vram_valid data for an aborted read is ignored.

Verification
REQ-037 Single tile, fmt_v2=0, opaque list {0x0000_0010, 0xF000_0000}, param_base=0x10_0000, ctrl bit31=1 -> one poly_req with poly_addr=0x10_0040, then tile_done and frame_done.
REQ-038 fmt_v2=1, puncht=0x0000_2000, list_en=5'b10000 -> only puncht walked; exactly 6 RA reads per entry.
REQ-039 Link word 0xE000_0100 -> next OPB read at 0x000100; walking continues there.
REQ-040 Self-looping link with MAX_LINKS=8 -> err=1, err_code=2 after 8 OPB reads; busy=0.
REQ-041 vram_wait held high 5 cycles -> vram_rd and vram_addr stable throughout; no duplicate read.
REQ-042 Reset asserted while poly_req=1 -> next cycle poly_req=0, state IDLE; a new start renders correctly.
